// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and the
// decoded-instruction class used by the issue logic and Control.
package cpu_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned FUNCT_MSB = 10;
    localparam int unsigned FUNCT_LSB = 0;

    localparam logic [5:0]  OP_NOP    = 6'd0;
    localparam logic [5:0]  OP_RTYPE  = 6'd2;
    localparam logic [5:0]  OP_LW     = 6'd3;
    localparam logic [5:0]  OP_SW     = 6'd4;
    localparam logic [10:0] FUNCT_MUL = 11'h2B2;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_MUL,
        CLS_LW,
        CLS_SW,
        CLS_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        instr_class_e     cls;
        logic             use_rs;
        logic             use_rt;
        logic             has_dest;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dest;
    } decoded_t;

    // Register usage of one instruction; undefined opcodes behave as nops.
    function automatic decoded_t decode_instr(input logic [31:0] instr);
        decoded_t    d;
        logic [5:0]  op;
        logic [10:0] funct;
        op         = instr[OP_MSB:OP_LSB];
        funct      = instr[FUNCT_MSB:FUNCT_LSB];
        d.cls      = CLS_ILLEGAL;
        d.use_rs   = 1'b0;
        d.use_rt   = 1'b0;
        d.has_dest = 1'b0;
        d.rs       = instr[RS_MSB:RS_LSB];
        d.rt       = instr[RT_MSB:RT_LSB];
        d.dest     = instr[RD_MSB:RD_LSB];
        case (op)
            OP_NOP: d.cls = CLS_NOP;
            OP_RTYPE: begin
                d.cls      = (funct == FUNCT_MUL) ? CLS_MUL : CLS_ALU;
                d.use_rs   = 1'b1;
                d.use_rt   = 1'b1;
                d.has_dest = 1'b1;
            end
            OP_LW: begin
                d.cls      = CLS_LW;
                d.use_rs   = 1'b1;
                d.has_dest = 1'b1;
                d.dest     = instr[RT_MSB:RT_LSB];
            end
            OP_SW: begin
                d.cls    = CLS_SW;
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            default: d.cls = CLS_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register wait counters: three combinational read ports, one set port,
// and a global decrement of every nonzero counter each cycle.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_addr,
    input  logic [REG_W-1:0] rt_addr,
    input  logic [REG_W-1:0] dest_addr,
    output logic [CNT_W-1:0] rs_cnt,
    output logic [CNT_W-1:0] rt_cnt,
    output logic [CNT_W-1:0] dest_cnt,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_addr,
    input  logic [CNT_W-1:0] set_val
);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    assign rs_cnt   = cnt_q[rs_addr];
    assign rt_cnt   = cnt_q[rt_addr];
    assign dest_cnt = cnt_q[dest_addr];

    // A new producer's latency overrides the decrement of its destination.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
        end
        if (set_en) begin
            cnt_d[set_addr] = set_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// ID->EX issue controller: stalls on RAW, WAW and multiplier-busy hazards
// using a register-availability scoreboard; counts stall cycles.
module hazard_scheduler
    import cpu_pkg::*;
#(
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned CNT_W    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        id_valid,
    input  logic        flush,
    output logic        issue,
    output logic        stall,
    output logic        illegal,
    output logic [15:0] stall_cnt
);

    localparam logic [CNT_W-1:0] ALU_WAIT  = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] LOAD_WAIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_WAIT  = CNT_W'(MUL_LAT - 1);

    decoded_t         dec;
    logic [CNT_W-1:0] rs_cnt;
    logic [CNT_W-1:0] rt_cnt;
    logic [CNT_W-1:0] dest_cnt;
    logic [CNT_W-1:0] own_wait;
    logic             is_mul;
    logic             ok;
    logic             active;
    logic             set_en;

    logic [CNT_W-1:0] mul_busy_q;
    logic [CNT_W-1:0] mul_busy_d;
    logic [15:0]      stall_cnt_q;
    logic [15:0]      stall_cnt_d;

    assign dec = decode_instr(instr);

    reg_scoreboard #(.CNT_W(CNT_W)) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (dec.rs),
        .rt_addr   (dec.rt),
        .dest_addr (dec.dest),
        .rs_cnt    (rs_cnt),
        .rt_cnt    (rt_cnt),
        .dest_cnt  (dest_cnt),
        .set_en    (set_en),
        .set_addr  (dec.dest),
        .set_val   (own_wait)
    );

    // Issue decision and next state; WAW allows a pending write that lands no later than ours.
    always_comb begin
        own_wait    = '0;
        is_mul      = 1'b0;
        ok          = 1'b1;
        active      = 1'b0;
        issue       = 1'b0;
        stall       = 1'b0;
        illegal     = 1'b0;
        set_en      = 1'b0;
        mul_busy_d  = (mul_busy_q != '0) ? mul_busy_q - CNT_W'(1) : mul_busy_q;
        stall_cnt_d = stall_cnt_q;

        case (dec.cls)
            CLS_ALU: own_wait = ALU_WAIT;
            CLS_LW:  own_wait = LOAD_WAIT;
            CLS_MUL: begin
                own_wait = MUL_WAIT;
                is_mul   = 1'b1;
            end
            default: own_wait = '0;
        endcase

        if (dec.use_rs && rs_cnt != '0)                 ok = 1'b0;
        if (dec.use_rt && rt_cnt != '0)                 ok = 1'b0;
        if (dec.has_dest && dest_cnt > own_wait)        ok = 1'b0;
        if (is_mul && mul_busy_q != '0)                 ok = 1'b0;

        active  = id_valid && !flush && !rst;
        issue   = active && ok;
        stall   = active && !ok;
        illegal = id_valid && !rst && (dec.cls == CLS_ILLEGAL);
        set_en  = issue && dec.has_dest;

        if (issue && is_mul) begin
            mul_busy_d = MUL_WAIT;
        end
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_busy_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            mul_busy_q  <= mul_busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        id_valid = 1'b0;
    logic        flush = 1'b0;
    logic        issue;
    logic        stall;
    logic        illegal;
    logic [15:0] stall_cnt;

    typedef struct {
        int          kind;   // 0: {issue,stall,illegal}, 1: stall_cnt
        logic [2:0]  hs;
        logic [15:0] cnt;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    localparam logic [10:0] F_ADD = 11'h2A0;
    localparam logic [10:0] F_MUL = 11'h2B2;

    hazard_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .id_valid  (id_valid),
        .flush     (flush),
        .issue     (issue),
        .stall     (stall),
        .illegal   (illegal),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [10:0] funct);
        return {6'd2, 5'(rs), 5'(rt), 5'(rd), funct};
    endfunction

    function automatic logic [31:0] enc_lw(input int rs, input int rt);
        return {6'd3, 5'(rs), 5'(rt), 16'h0000};
    endfunction

    task automatic step(input logic [31:0] ins, input logic v, input logic fl, input logic r,
                        input logic ei, input logic es, input logic eil);
        exp_t x;
        @(posedge clk);
        #1;
        instr    = ins;
        id_valid = v;
        flush    = fl;
        rst      = r;
        x.kind = 0;
        x.hs   = {ei, es, eil};
        x.cnt  = 16'h0;
        x.id   = step_no;
        exp_q.push_back(x);
        step_no++;
    endtask

    task automatic chk_cnt(input logic [15:0] c);
        exp_t x;
        x.kind = 1;
        x.hs   = 3'b000;
        x.cnt  = c;
        x.id   = step_no - 1;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (e.kind == 0) begin
                if ({issue, stall, illegal} !== e.hs) begin
                    errors++;
                    $display("FAIL hs step%0d: {issue,stall,illegal} got %b want %b",
                             e.id, {issue, stall, illegal}, e.hs);
                end
            end else begin
                if (stall_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL stall_cnt step%0d: got %0d want %0d", e.id, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset holds outputs low even with a valid instruction present
        step(32'h0fe00001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(32'h0fe00001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_cnt(16'd0);

        // reference program: issues 0,1,3,6,7,8,9,10; stalls 2,4,5
        step(32'h0fe00001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_cnt(16'd0);
        step(32'h0fe10002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(32'h080122b2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(32'h080122b2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(32'h08642aa0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(32'h08642aa0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(32'h08642aa0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(32'h088532a2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(32'h13e6dfff, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(32'h08210aa5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(32'h08432aa0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_cnt(16'd3);
        idle(3);

        // dependent ALU chain never stalls; source == dest included
        step(enc_r(0, 0, 1, F_ADD), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(enc_r(1, 0, 2, F_ADD), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(enc_r(2, 0, 3, F_ADD), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(enc_r(3, 3, 3, F_ADD), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_cnt(16'd3);
        idle(3);

        // back-to-back independent muls: structural stall of 2 cycles
        step(enc_r(11, 12, 10, F_MUL), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(enc_r(14, 15, 13, F_MUL), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(enc_r(14, 15, 13, F_MUL), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(enc_r(14, 15, 13, F_MUL), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_cnt(16'd5);
        idle(3);

        // WAW: lw r4 right after mul r4 waits one cycle
        step(enc_r(20, 21, 4, F_MUL), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(enc_lw(22, 4),           1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(enc_lw(22, 4),           1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_cnt(16'd6);
        idle(3);

        // illegal opcode issues as a nop and writes nothing
        step(32'hFC073800, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(32'hFC073800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(enc_r(7, 7, 8, F_ADD), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // reset in the middle of a stall clears tracking and the stall count
        step(enc_r(20, 21, 4, F_MUL), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(enc_r(4, 4, 5, F_ADD),   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cnt(16'd6);
        step(enc_r(4, 4, 5, F_ADD),   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_cnt(16'd7);
        step(enc_r(4, 4, 5, F_ADD),   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_cnt(16'd0);
        idle(3);

        // flush drops a stall and a flushed producer leaves no scoreboard entry
        step(enc_r(20, 21, 4, F_MUL), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(enc_r(4, 4, 5, F_ADD),   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(enc_r(4, 4, 5, F_ADD),   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(enc_r(4, 4, 5, F_ADD),   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(enc_lw(22, 9),           1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(enc_r(9, 9, 10, F_ADD),  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_cnt(16'd1);
        idle(2);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
